// File: rtl/hdmi_tmds_channel_enc.sv
// -----------------------------------------------------------------------------
// hdmi_tmds_channel_enc
//
// One lane of an HDMI 1.4 TMDS encoder. Each clock the lane turns the current
// period type (control, video, guard band, data island) and its payload into
// one 10-bit TMDS symbol. Video uses the DC-balanced 8b/10b transition
// minimising code; data islands use TERC4. Three instances (CHANNEL 0..2)
// form a complete link.
//
// Parameters
//   CHANNEL      lane index 0..2: selects the control-bit source and the
//                guard-band codes
//   PIPE_STAGES  extra output register stages after the encode register
//                (0..4); latency is 1 + PIPE_STAGES in every mode
//
// Ports
//   clk       in   pixel clock
//   reset     in   synchronous, active-high reset
//   mode      in   [2:0] 0 CTRL, 1 VIDEO, 2 VIDEO_GB, 3 TERC4, 4 DATA_GB,
//                  5..7 behave as CTRL
//   h_sync    in   HSYNC (control source on lane 0)
//   v_sync    in   VSYNC (control source on lane 0)
//   ctl       in   [1:0] {CTLn+1,CTLn} control source on lanes 1 and 2
//   aux       in   [3:0] TERC4 nibble for data-island periods
//   data_in   in   [7:0] pixel component for video periods
//   data_out  out  [9:0] TMDS symbol, bit 0 is transmitted first
// -----------------------------------------------------------------------------
module hdmi_tmds_channel_enc #(
  parameter int CHANNEL     = 0,
  parameter int PIPE_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] mode,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic [1:0] ctl,
  input  logic [3:0] aux,
  input  logic [7:0] data_in,
  output logic [9:0] data_out
);

  typedef enum logic [2:0] {
    MODE_CTRL     = 3'd0,
    MODE_VIDEO    = 3'd1,
    MODE_VIDEO_GB = 3'd2,
    MODE_TERC4    = 3'd3,
    MODE_DATA_GB  = 3'd4
  } mode_e;

  // Control code 00; also the idle symbol the link shows out of reset.
  localparam logic [9:0] SYM_RESET = 10'b1101010100;

  // Guard-band codes. Lane 1 uses the complementary pattern in both guard
  // band types; lanes 0/2 differ between video and data guard bands.
  localparam logic [9:0] SYM_GB_A  = 10'b1011001100;
  localparam logic [9:0] SYM_GB_B  = 10'b0100110011;

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    case (c)
      2'b00:   ctrl_sym = 10'b1101010100;
      2'b01:   ctrl_sym = 10'b0010101011;
      2'b10:   ctrl_sym = 10'b0101010100;
      default: ctrl_sym = 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] terc4(input logic [3:0] n);
    case (n)
      4'd0:    terc4 = 10'b1010011100;
      4'd1:    terc4 = 10'b1001100011;
      4'd2:    terc4 = 10'b1011100100;
      4'd3:    terc4 = 10'b1011100010;
      4'd4:    terc4 = 10'b0101110001;
      4'd5:    terc4 = 10'b0100011110;
      4'd6:    terc4 = 10'b0110001110;
      4'd7:    terc4 = 10'b0100111100;
      4'd8:    terc4 = 10'b1011001100;
      4'd9:    terc4 = 10'b0100111001;
      4'd10:   terc4 = 10'b0110011100;
      4'd11:   terc4 = 10'b1011000110;
      4'd12:   terc4 = 10'b1010001110;
      4'd13:   terc4 = 10'b1001110001;
      4'd14:   terc4 = 10'b0101100011;
      default: terc4 = 10'b1011000011;
    endcase
  endfunction

  function automatic logic [3:0] ones8(input logic [7:0] v);
    ones8 = '0;
    for (int i = 0; i < 8; i++) ones8 = ones8 + {3'b000, v[i]};
  endfunction

  // Running disparity: (#ones - #zeros) sent so far in the current video run.
  logic signed [5:0] cnt;
  logic        [9:0] enc_q;

  // ---------------------------------------------------------------------------
  // Video 8b/10b encode
  // ---------------------------------------------------------------------------
  logic        [3:0] n1_d;
  logic              use_xnor;
  logic        [8:0] q_m;
  logic        [3:0] n1_q;
  logic        [3:0] n0_q;
  logic signed [5:0] diff;       // N1(q_m) - N0(q_m)
  logic        [9:0] video_sym;
  logic signed [5:0] video_cnt;

  always_comb begin
    // NOTE: every signal gets a value before any branch so no path through
    // this block leaves one unassigned, which would infer a latch.
    q_m       = '0;
    video_sym = '0;
    video_cnt = '0;

    n1_d     = ones8(data_in);
    // XNOR chaining when the byte is ones-heavy keeps transitions low.
    use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !data_in[0]);

    q_m[0] = data_in[0];
    for (int i = 1; i < 8; i++)
      q_m[i] = use_xnor ? ~(q_m[i-1] ^ data_in[i]) : (q_m[i-1] ^ data_in[i]);
    q_m[8] = ~use_xnor;

    n1_q = ones8(q_m[7:0]);
    n0_q = 4'd8 - n1_q;
    diff = {2'b00, n1_q} - {2'b00, n0_q};

    if ((cnt == 6'sd0) || (n1_q == n0_q)) begin
      // Balanced case: bit 9 just records whether bits were inverted.
      video_sym = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      video_cnt = q_m[8] ? (cnt + diff) : (cnt - diff);
    end else if ((!cnt[5] && (n1_q > n0_q)) || (cnt[5] && (n0_q > n1_q))) begin
      // Invert to pull the disparity back towards zero.
      video_sym = {1'b1, q_m[8], ~q_m[7:0]};
      video_cnt = cnt + {4'b0000, q_m[8], 1'b0} - diff;
    end else begin
      video_sym = {1'b0, q_m[8], q_m[7:0]};
      video_cnt = cnt + diff - {4'b0000, ~q_m[8], 1'b0};
    end
  end

  // ---------------------------------------------------------------------------
  // Period-type select
  // ---------------------------------------------------------------------------
  logic [1:0] ctrl_bits;
  logic [9:0] enc_d;
  logic signed [5:0] cnt_d;

  always_comb begin
    ctrl_bits = (CHANNEL == 0) ? {v_sync, h_sync} : ctl;
    enc_d     = ctrl_sym(ctrl_bits);
    cnt_d     = '0;   // any non-video period restarts the disparity count
    case (mode)
      MODE_VIDEO: begin
        enc_d = video_sym;
        cnt_d = video_cnt;
      end
      MODE_VIDEO_GB: enc_d = (CHANNEL == 1) ? SYM_GB_B : SYM_GB_A;
      MODE_TERC4:    enc_d = terc4(aux);
      MODE_DATA_GB:  enc_d = (CHANNEL == 0) ? terc4({2'b11, v_sync, h_sync})
                                            : SYM_GB_B;
      default:       enc_d = ctrl_sym(ctrl_bits);
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      enc_q <= SYM_RESET;
    end else begin
      cnt   <= cnt_d;
      enc_q <= enc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output pipeline
  // ---------------------------------------------------------------------------
  generate
    if (PIPE_STAGES == 0) begin : g_no_pipe
      assign data_out = enc_q;
    end else begin : g_pipe
      logic [9:0] pipe_q [PIPE_STAGES];

      // NOTE: the stage array is reset, unlike a plain storage memory, so
      // that a reset mid-stream flushes in-flight symbols on the same edge
      // and the serialiser sees a clean idle code immediately.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < PIPE_STAGES; i++) pipe_q[i] <= SYM_RESET;
        end else begin
          pipe_q[0] <= enc_q;
          for (int i = 1; i < PIPE_STAGES; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign data_out = pipe_q[PIPE_STAGES-1];
    end
  endgenerate

endmodule

// File: tb/tb_hdmi_tmds_channel_enc.sv
// -----------------------------------------------------------------------------
// tb_hdmi_tmds_channel_enc
//
// Four lane instances share one stimulus stream:
//   u0: CHANNEL 0, PIPE_STAGES 2    u1: CHANNEL 1, PIPE_STAGES 2
//   u2: CHANNEL 2, PIPE_STAGES 0    u3: CHANNEL 1, PIPE_STAGES 4
// Each driven cycle pushes an expected symbol per instance into a queue;
// each clock the oldest entry is popped and compared with data_out.
// A directed table supplies literal expected symbols for one chosen
// instance per row; a reference model covers the other instances and the
// random phase.
// -----------------------------------------------------------------------------
module tb_hdmi_tmds_channel_enc;

  localparam logic [9:0] SYM_RESET = 10'b1101010100;
  localparam int NI = 4;
  localparam int CH  [NI] = '{0, 1, 2, 1};
  localparam int LAT [NI] = '{3, 3, 1, 5};

  localparam logic [9:0] TERC4_REF [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] mode;
  logic       h_sync, v_sync;
  logic [1:0] ctl;
  logic [3:0] aux;
  logic [7:0] data_in;
  logic [9:0] dout [NI];

  always #5 clk = ~clk;

  hdmi_tmds_channel_enc #(.CHANNEL(0), .PIPE_STAGES(2)) u0 (
    .clk(clk), .reset(reset), .mode(mode), .h_sync(h_sync), .v_sync(v_sync),
    .ctl(ctl), .aux(aux), .data_in(data_in), .data_out(dout[0]));
  hdmi_tmds_channel_enc #(.CHANNEL(1), .PIPE_STAGES(2)) u1 (
    .clk(clk), .reset(reset), .mode(mode), .h_sync(h_sync), .v_sync(v_sync),
    .ctl(ctl), .aux(aux), .data_in(data_in), .data_out(dout[1]));
  hdmi_tmds_channel_enc #(.CHANNEL(2), .PIPE_STAGES(0)) u2 (
    .clk(clk), .reset(reset), .mode(mode), .h_sync(h_sync), .v_sync(v_sync),
    .ctl(ctl), .aux(aux), .data_in(data_in), .data_out(dout[2]));
  hdmi_tmds_channel_enc #(.CHANNEL(1), .PIPE_STAGES(4)) u3 (
    .clk(clk), .reset(reset), .mode(mode), .h_sync(h_sync), .v_sync(v_sync),
    .ctl(ctl), .aux(aux), .data_in(data_in), .data_out(dout[3]));

  logic [9:0] sb [NI][$];
  int         mcnt [NI];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cycle    = 0;

  typedef struct {
    logic [2:0] m;
    logic       h;
    logic       v;
    logic [1:0] c;
    logic [3:0] a;
    logic [7:0] d;
    int         inst;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference lane model; updates the running disparity of instance idx.
  function automatic logic [9:0] model(input int idx, input logic [2:0] m,
                                       input logic h, input logic v,
                                       input logic [1:0] c, input logic [3:0] a,
                                       input logic [7:0] d);
    logic [9:0] r;
    logic [1:0] cb;
    logic [7:0] qm;
    logic       qm8;
    logic       use_xnor;
    int         n1d, n1, n0;
    cb = (CH[idx] == 0) ? {v, h} : c;
    case (cb)
      2'b00:   r = 10'b1101010100;
      2'b01:   r = 10'b0010101011;
      2'b10:   r = 10'b0101010100;
      default: r = 10'b1010101011;
    endcase
    if (m == 3'd1) begin
      n1d      = $countones(d);
      use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
      qm[0]    = d[0];
      for (int i = 1; i < 8; i++)
        qm[i] = use_xnor ? !(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm8 = !use_xnor;
      n1  = $countones(qm);
      n0  = 8 - n1;
      if (mcnt[idx] == 0 || n1 == n0) begin
        r = {!qm8, qm8, qm8 ? qm : ~qm};
        mcnt[idx] += qm8 ? (n1 - n0) : (n0 - n1);
      end else if ((mcnt[idx] > 0 && n1 > n0) || (mcnt[idx] < 0 && n0 > n1)) begin
        r = {1'b1, qm8, ~qm};
        mcnt[idx] += 2 * int'(qm8) + (n0 - n1);
      end else begin
        r = {1'b0, qm8, qm};
        mcnt[idx] += (n1 - n0) - 2 * int'(!qm8);
      end
    end else begin
      mcnt[idx] = 0;
      if (m == 3'd2)
        r = (CH[idx] == 1) ? 10'b0100110011 : 10'b1011001100;
      else if (m == 3'd3)
        r = TERC4_REF[a];
      else if (m == 3'd4)
        r = (CH[idx] == 0) ? TERC4_REF[{2'b11, v, h}] : 10'b0100110011;
    end
    return r;
  endfunction

  // One clock: drive inputs, push expectations, clock, pop and compare.
  // fi/fe override the model's expectation for instance fi with a literal.
  task automatic step(input logic rst, input logic [2:0] m, input logic h,
                      input logic v, input logic [1:0] c, input logic [3:0] a,
                      input logic [7:0] d, input int fi, input logic [9:0] fe);
    logic [9:0] e;
    reset = rst; mode = m; h_sync = h; v_sync = v; ctl = c; aux = a; data_in = d;
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        e = model(i, m, h, v, c, a, d);
        if (i == fi) e = fe;
        sb[i].push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
    cycle++;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        check($sformatf("u%0d reset cyc%0d", i, cycle), dout[i], SYM_RESET);
        sb[i].delete();
        mcnt[i] = 0;
        for (int k = 1; k < LAT[i]; k++) sb[i].push_back(SYM_RESET);
      end else begin
        e = sb[i].pop_front();
        check($sformatf("u%0d cyc%0d", i, cycle), dout[i], e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 3'd0, 1'b0, 1'b0, 2'b00, 4'd0, 8'h00, -1, '0);
  endtask

  initial begin
    // Directed vectors: {mode, h, v, ctl, aux, data, instance, expected}
    vecs.push_back('{3'd1, 1'b0, 1'b0, 2'b00, 4'd0, 8'h00, 0, 10'b0100000000});
    vecs.push_back('{3'd1, 1'b0, 1'b0, 2'b00, 4'd0, 8'h00, 0, 10'b1111111111});
    vecs.push_back('{3'd0, 1'b0, 1'b0, 2'b00, 4'd0, 8'h00, 0, 10'b1101010100});
    vecs.push_back('{3'd1, 1'b0, 1'b0, 2'b00, 4'd0, 8'hFF, 0, 10'b1000000000});
    vecs.push_back('{3'd0, 1'b0, 1'b0, 2'b00, 4'd0, 8'h00, 0, 10'b1101010100});
    vecs.push_back('{3'd1, 1'b0, 1'b0, 2'b00, 4'd0, 8'hFF, 0, 10'b1000000000});
    vecs.push_back('{3'd0, 1'b0, 1'b1, 2'b00, 4'd0, 8'h00, 0, 10'b0101010100});
    vecs.push_back('{3'd0, 1'b0, 1'b0, 2'b11, 4'd0, 8'h00, 1, 10'b1010101011});
    vecs.push_back('{3'd0, 1'b0, 1'b0, 2'b01, 4'd0, 8'h00, 1, 10'b0010101011});
    vecs.push_back('{3'd2, 1'b0, 1'b0, 2'b00, 4'd0, 8'h00, 1, 10'b0100110011});
    vecs.push_back('{3'd2, 1'b0, 1'b0, 2'b00, 4'd0, 8'h00, 0, 10'b1011001100});
    vecs.push_back('{3'd4, 1'b0, 1'b1, 2'b00, 4'd0, 8'h00, 0, 10'b0101100011});
    vecs.push_back('{3'd4, 1'b0, 1'b0, 2'b00, 4'd0, 8'h00, 1, 10'b0100110011});
    vecs.push_back('{3'd5, 1'b1, 1'b0, 2'b00, 4'd0, 8'h00, 0, 10'b0010101011});
    vecs.push_back('{3'd7, 1'b0, 1'b0, 2'b10, 4'd0, 8'h00, 1, 10'b0101010100});
    for (int k = 0; k < 16; k++)
      vecs.push_back('{3'd3, 1'b0, 1'b0, 2'b00, 4'(k), 8'h00, 1, TERC4_REF[k]});

    // Reset held for three cycles with CTRL inputs, then idle after release.
    for (int k = 0; k < 3; k++) step(1'b1, 3'd0, 1'b0, 1'b0, 2'b00, 4'd0, 8'h00, -1, '0);
    idle(2);

    foreach (vecs[k])
      step(1'b0, vecs[k].m, vecs[k].h, vecs[k].v, vecs[k].c, vecs[k].a, vecs[k].d,
           vecs[k].inst, vecs[k].exp);
    idle(6);

    // Mid-stream reset: video symbols in flight are replaced, and the
    // disparity restarts so 0x00 again encodes as 0100000000.
    step(1'b0, 3'd1, 1'b0, 1'b0, 2'b00, 4'd0, 8'h00, -1, '0);
    step(1'b0, 3'd1, 1'b0, 1'b0, 2'b00, 4'd0, 8'h3C, -1, '0);
    step(1'b0, 3'd1, 1'b0, 1'b0, 2'b00, 4'd0, 8'h01, -1, '0);
    step(1'b1, 3'd1, 1'b0, 1'b0, 2'b00, 4'd0, 8'h55, -1, '0);
    step(1'b0, 3'd1, 1'b0, 1'b0, 2'b00, 4'd0, 8'h00, 2, 10'b0100000000);
    step(1'b0, 3'd1, 1'b0, 1'b0, 2'b00, 4'd0, 8'h00, 2, 10'b1111111111);
    idle(6);

    // Random mix of single-cycle periods and long video runs.
    begin
      int run_left = 0;
      for (int k = 0; k < 4000; k++) begin
        logic [2:0] m;
        if (run_left > 0) begin
          m = 3'd1;
          run_left--;
        end else if ($urandom_range(0, 1) == 0) begin
          m = 3'd1;
          run_left = $urandom_range(1, 60);
        end else begin
          m = 3'($urandom_range(0, 7));
        end
        step(1'b0, m, 1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom),
             8'($urandom), -1, '0);
      end
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
